tof_capture: RTL and testbench
==============================

# tof_capture

Time-of-flight capture stage directly downstream of the 14-bit coarse counter in the clk5 TDC domain. Drives the counter's count enable, samples the running coarse count on the start hit and on up to MAX_ECHO stop hits, and converts each stop into a wrap-safe elapsed count. Records are queued in a small FIFO with a valid/ready output so the readout logic can drain them at its own pace.

## Interface
- CNT_W, 14: coarse count width.
- MAX_ECHO, 4: maximum stop hits recorded per window, 1..15.
- TIMEOUT, 12000: window length in clk5 cycles, 1..2^CNT_W-1.
- FIFO_DEPTH, 8: output queue depth, power of two.
- clk5  in  1  sole clock.
- rst  in  1  reset, asynchronous assert, active-high.
- start_hit  in  1  one-cycle start pulse.
- stop_hit  in  1  one-cycle stop/echo pulse.
- coarse_cnt  in  CNT_W  running coarse count.
- cnt_en  out  1  enable to the coarse counter.
- busy  out  1  window open.
- tof_data  out  CNT_W  elapsed count; all ones means no echo.
- tof_idx  out  4  echo index, 0-based.
- tof_last  out  1  final record of the window.
- tof_valid  out  1  FIFO head valid.
- tof_ready  in  1  consumer accepts head.
- drop_cnt  out  8  saturating count of dropped records.

## Operation
- Reset: FSM IDLE; cnt_en, busy, tof_valid, tof_last = 0; tof_data, tof_idx = 0; drop_cnt = 0; FIFO empty; pending register empty.
- FSM states: IDLE, MEASURE, CLOSE.
- IDLE -> MEASURE on start_hit. Capture start_cnt = coarse_cnt, clear echo count and timer, and assert cnt_en and busy from the next cycle.
- MEASURE: timer increments every cycle.
  - On stop_hit, compute elapsed = (coarse_cnt - start_cnt) mod 2^CNT_W.
  - The elapsed value goes to the pending register with idx = echo count. Any previously pending record is pushed to the FIFO with last = 0.
  - Go to CLOSE when echo count reaches MAX_ECHO or timer == TIMEOUT-1.
- CLOSE, one cycle:
  - If a record is pending, push it with last = 1.
  - If the window had zero echoes, push tof_data = all ones, idx = 0, last = 1.
  - Drop cnt_en and busy, then go to IDLE.
- start_hit outside IDLE is ignored.
- stop_hit in IDLE or CLOSE is ignored.
- stop_hit coinciding with timeout: the stop is captured, and that record is the last.
- Push with FIFO full: the record is discarded and drop_cnt increments, saturating at 255. A simultaneous pop frees the slot, so the push succeeds.
- FIFO: tof_valid = not empty. A pop occurs when tof_valid && tof_ready. Outputs show the head entry.

## Timing
- The start_cnt and stop samples use coarse_cnt on the same clk5 edge at which the hit is high.
- Stop to FIFO entry latency: one cycle after the next stop, or at CLOSE for the final echo.
- FIFO write to tof_valid: one cycle.
- cnt_en rises one cycle after start_hit and falls one cycle after CLOSE.
- Back-to-back windows: the earliest next start_hit is accepted one cycle after CLOSE.
- rst mid-window: immediate return to reset values. FIFO contents are lost.

## Structure
- Shared package holds:
  - FSM state enum {IDLE, MEASURE, CLOSE};
  - record struct {data, idx, last};
  - NO_ECHO constant (all ones).
- One sub-module, tof_fifo: synchronous FIFO with full/empty flags and same-cycle push/pop. It is parameterized by depth and record width.

## Test plan
- start at coarse_cnt = 100, stops at counts 150 and 400, then timeout -> records (50, idx 0, last 0) and (300, idx 1, last 1).
- start at coarse_cnt = 16380, stop at count 5 (wrapped) -> tof_data = 9.
- start, no stops, TIMEOUT elapses -> single record 0x3FFF, idx 0, last 1; cnt_en high for exactly TIMEOUT+1 cycles.
- 5 stops with MAX_ECHO = 4 -> 4 records, idx 0..3, last on idx 3; the 5th stop is ignored and the FSM is back in IDLE.
- tof_ready held low across three 4-echo windows -> 8 records retained, drop_cnt = 4. Releasing ready drains them in order.
- rst asserted during MEASURE -> cnt_en, busy and tof_valid low immediately. The next start runs a clean window.

Source files
------------

// File: rtl/tof_capture_pkg.sv
// Shared types for the TDC time-of-flight capture stage: FSM states, record layout, no-echo marker.
package tof_capture_pkg;

   localparam int TOF_CNT_W = 14;
   localparam int TOF_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      CLOSE   = 2'd2
   } tof_state_t;

   typedef struct packed {
      logic [TOF_CNT_W-1:0] data;
      logic [TOF_IDX_W-1:0] idx;
      logic                 last;
   } tof_rec_t;

   localparam logic [TOF_CNT_W-1:0] NO_ECHO = '1;

endpackage

// File: rtl/tof_fifo.sv
// Synchronous record FIFO with same-cycle push/pop; head visible one cycle after the write.
// A push while full is refused (wr_ok low) unless a pop in the same cycle frees the slot.
module tof_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 19
) (
   input  logic         clk5,
   input  logic         rst,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   output logic         wr_ok,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_pop;

   assign full   = (count == (AW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign do_pop = rd_rdy && !empty;
   assign wr_ok  = wr_vld && (!full || do_pop);
   // Gate the head so an empty queue presents zeros rather than stale storage
   assign rd_dat = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk5) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   always_ff @(posedge clk5 or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tof_capture.sv
// Time-of-flight capture: samples coarse count on start/stop hits and queues wrap-safe elapsed records.
// A stop reaches the FIFO on the next stop or at close; full FIFO drops and counts, head holds until tof_ready.
module tof_capture
   import tof_capture_pkg::*;
#(
   parameter int CNT_W      = TOF_CNT_W,
   parameter int MAX_ECHO   = 4,
   parameter int TIMEOUT    = 12000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk5,
   input  logic             rst,
   input  logic             start_hit,
   input  logic             stop_hit,
   input  logic [CNT_W-1:0] coarse_cnt,
   output logic             cnt_en,
   output logic             busy,
   output logic [CNT_W-1:0] tof_data,
   output logic [3:0]       tof_idx,
   output logic             tof_last,
   output logic             tof_valid,
   input  logic             tof_ready,
   output logic [7:0]       drop_cnt
);

   localparam logic [3:0]       ECHO_LAST = 4'(MAX_ECHO - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

   tof_state_t       state;
   tof_state_t       state_nxt;
   logic [CNT_W-1:0] start_cnt;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] elapsed;
   logic [3:0]       echo_cnt;
   logic             pend_vld;
   tof_rec_t         pend_rec;
   logic             push;
   logic             push_ok;
   tof_rec_t         push_rec;
   tof_rec_t         head;
   logic             fifo_full;
   logic             fifo_empty;

   // Modular subtraction keeps the result correct across a coarse counter wrap
   assign elapsed = coarse_cnt - start_cnt;

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      push_rec  = pend_rec;
      case (state)
         IDLE: begin
            if (start_hit) begin
               state_nxt = MEASURE;
            end
         end
         MEASURE: begin
            if (stop_hit) begin
               push          = pend_vld;
               push_rec.last = 1'b0;
            end
            if ((stop_hit && echo_cnt == ECHO_LAST) || timer == TMO_LAST) begin
               state_nxt = CLOSE;
            end
         end
         CLOSE: begin
            push      = 1'b1;
            state_nxt = IDLE;
            if (pend_vld) begin
               push_rec.last = 1'b1;
            end else begin
               push_rec = '{data: NO_ECHO, idx: '0, last: 1'b1};
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk5 or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         start_cnt <= '0;
         timer     <= '0;
         echo_cnt  <= '0;
         pend_vld  <= 1'b0;
         pend_rec  <= '0;
         drop_cnt  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start_hit) begin
                  start_cnt <= coarse_cnt;
                  timer     <= '0;
                  echo_cnt  <= '0;
                  pend_vld  <= 1'b0;
               end
            end
            MEASURE: begin
               timer <= timer + 1'b1;
               if (stop_hit) begin
                  pend_rec <= '{data: elapsed, idx: echo_cnt, last: 1'b0};
                  pend_vld <= 1'b1;
                  echo_cnt <= echo_cnt + 1'b1;
               end
            end
            CLOSE:   pend_vld <= 1'b0;
            default: pend_vld <= 1'b0;
         endcase
         if (push && !push_ok && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   assign cnt_en = (state != IDLE);
   assign busy   = (state != IDLE);

   tof_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(tof_rec_t))
   ) u_fifo (
      .clk5   (clk5),
      .rst    (rst),
      .wr_vld (push),
      .wr_dat (push_rec),
      .wr_ok  (push_ok),
      .rd_rdy (tof_ready),
      .rd_dat (head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign tof_valid = !fifo_empty;
   assign tof_data  = head.data;
   assign tof_idx   = head.idx;
   assign tof_last  = head.last;

endmodule

// File: tb/tb_tof_capture.sv
// Bench for tof_capture: window-level reference model with per-cycle comparison plus directed literal checks.
module tb_tof_capture;

   localparam int CW     = 14;
   localparam int ME     = 4;
   localparam int TMO    = 64;
   localparam int DEPTH  = 8;
   localparam int NOECHO = 16383;

   logic          clk5 = 1'b0;
   logic          rst;
   logic          start_hit;
   logic          stop_hit;
   logic [CW-1:0] coarse_cnt;
   logic          cnt_en;
   logic          busy;
   logic [CW-1:0] tof_data;
   logic [3:0]    tof_idx;
   logic          tof_last;
   logic          tof_valid;
   logic          tof_ready;
   logic [7:0]    drop_cnt;

   tof_capture #(
      .CNT_W      (CW),
      .MAX_ECHO   (ME),
      .TIMEOUT    (TMO),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk5       (clk5),
      .rst        (rst),
      .start_hit  (start_hit),
      .stop_hit   (stop_hit),
      .coarse_cnt (coarse_cnt),
      .cnt_en     (cnt_en),
      .busy       (busy),
      .tof_data   (tof_data),
      .tof_idx    (tof_idx),
      .tof_last   (tof_last),
      .tof_valid  (tof_valid),
      .tof_ready  (tof_ready),
      .drop_cnt   (drop_cnt)
   );

   always #5 clk5 = ~clk5;

   typedef struct {
      int data;
      int idx;
      int last;
   } mrec_t;

   // Reference model: window open flag, age, list of elapsed echo values, queued records
   bit    m_open;
   bit    m_closing;
   int    m_age;
   int    m_start;
   int    m_drop;
   int    m_echo[$];
   mrec_t mq[$];
   mrec_t log_q[$];

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_open    = 1'b0;
      m_closing = 1'b0;
      m_age     = 0;
      m_start   = 0;
      m_drop    = 0;
      m_echo.delete();
      mq.delete();
   endtask

   task automatic model_step();
      bit    have_push;
      bit    pop;
      mrec_t pr;
      have_push = 1'b0;
      pr        = '{0, 0, 0};
      if (rst) return;
      pop = (mq.size() > 0) && tof_ready;
      if (m_closing) begin
         have_push = 1'b1;
         if (m_echo.size() > 0) pr = '{m_echo[$], m_echo.size() - 1, 1};
         else                   pr = '{NOECHO, 0, 1};
         m_open    = 1'b0;
         m_closing = 1'b0;
      end else if (m_open) begin
         if (stop_hit) begin
            if (m_echo.size() > 0) begin
               have_push = 1'b1;
               pr = '{m_echo[$], m_echo.size() - 1, 0};
            end
            m_echo.push_back((int'(coarse_cnt) - m_start + 16384) % 16384);
         end
         if (m_echo.size() == ME || m_age == TMO - 1) m_closing = 1'b1;
         m_age++;
      end else if (start_hit) begin
         m_open  = 1'b1;
         m_age   = 0;
         m_start = int'(coarse_cnt);
         m_echo.delete();
      end
      if (pop) void'(mq.pop_front());
      if (have_push) begin
         if (mq.size() < DEPTH) mq.push_back(pr);
         else if (m_drop < 255) m_drop++;
      end
   endtask

   task automatic compare();
      chk("cnt_en", cnt_en, m_open);
      chk("busy", busy, m_open);
      chk("tof_valid", tof_valid, mq.size() > 0);
      chk("drop_cnt", drop_cnt, m_drop);
      if (mq.size() > 0) begin
         chk("tof_data", tof_data, mq[0].data);
         chk("tof_idx", tof_idx, mq[0].idx);
         chk("tof_last", tof_last, mq[0].last);
      end
   endtask

   // One clock: model samples the same edge as the DUT, outputs compared mid-cycle
   task automatic tick();
      @(posedge clk5);
      model_step();
      @(negedge clk5);
      compare();
   endtask

   task automatic hit(input bit s, input bit p, input int c);
      start_hit  = s;
      stop_hit   = p;
      coarse_cnt = CW'(c);
      tick();
      start_hit = 1'b0;
      stop_hit  = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 1000) begin
         tick();
         n++;
      end
      chk("wait_idle_timeout", busy, 0);
   endtask

   task automatic drain();
      log_q.delete();
      tof_ready = 1'b1;
      for (int n = 0; n < 64; n++) begin
         if (!tof_valid) break;
         log_q.push_back('{int'(tof_data), int'(tof_idx), int'(tof_last)});
         tick();
      end
      tof_ready = 1'b0;
      chk("drain_empty", tof_valid, 0);
   endtask

   task automatic expect_rec(input int i, input int d, input int x, input int l);
      if (i < log_q.size()) begin
         chk("rec_data", log_q[i].data, d);
         chk("rec_idx", log_q[i].idx, x);
         chk("rec_last", log_q[i].last, l);
      end else begin
         chk("rec_missing", log_q.size(), i + 1);
      end
   endtask

   initial begin
      int n;
      int rdy_bias;
      rst        = 1'b1;
      start_hit  = 1'b0;
      stop_hit   = 1'b0;
      coarse_cnt = '0;
      tof_ready  = 1'b0;
      model_reset();
      tick();
      tick();
      chk("rst_cnt_en", cnt_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", tof_valid, 0);
      chk("rst_last", tof_last, 0);
      chk("rst_data", tof_data, 0);
      chk("rst_idx", tof_idx, 0);
      chk("rst_drop", drop_cnt, 0);
      rst = 1'b0;
      tick();

      // Two echoes then timeout
      hit(1, 0, 100);
      chk("cnt_en_after_start", cnt_en, 1);
      tick();
      hit(0, 1, 150);
      tick();
      hit(0, 1, 400);
      wait_idle();
      tick();
      drain();
      chk("t1_count", log_q.size(), 2);
      expect_rec(0, 50, 0, 0);
      expect_rec(1, 300, 1, 1);

      // Counter wrap between start and stop
      hit(1, 0, 16380);
      hit(0, 1, 5);
      wait_idle();
      tick();
      drain();
      chk("t2_count", log_q.size(), 1);
      expect_rec(0, 9, 0, 1);

      // No echo: cnt_en length and the no-echo record
      hit(1, 0, 7);
      n = 0;
      while (cnt_en && n < 500) begin
         n++;
         tick();
      end
      chk("t3_cnt_en_cycles", n, TMO + 1);
      tick();
      drain();
      chk("t3_count", log_q.size(), 1);
      expect_rec(0, NOECHO, 0, 1);

      // Five consecutive stops, only four recorded
      hit(1, 0, 1000);
      for (int k = 1; k <= 5; k++) hit(0, 1, 1000 + k);
      chk("t4_idle_after_5th", busy, 0);
      tick();
      drain();
      chk("t4_count", log_q.size(), 4);
      for (int k = 0; k < 4; k++) expect_rec(k, k + 1, k, (k == 3) ? 1 : 0);

      // Ready held low over three full windows: eight kept, four dropped
      for (int w = 0; w < 3; w++) begin
         hit(1, 0, 2000 * (w + 1));
         for (int k = 1; k <= 4; k++) hit(0, 1, 2000 * (w + 1) + 10 * k);
         tick();
         tick();
      end
      chk("t5_drop", drop_cnt, 4);
      drain();
      chk("t5_count", log_q.size(), 8);
      for (int k = 0; k < 8; k++) expect_rec(k, 10 * (k % 4 + 1), k % 4, (k % 4 == 3) ? 1 : 0);

      // Reset in the middle of a window with records queued
      rst = 1'b1;
      model_reset();
      tick();
      rst = 1'b0;
      tick();
      hit(1, 0, 0);
      hit(0, 1, 10);
      hit(0, 1, 20);
      chk("t6_valid_before_rst", tof_valid, 1);
      rst = 1'b1;
      model_reset();
      #1;
      chk("t6_rst_cnt_en", cnt_en, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_valid", tof_valid, 0);
      tick();
      rst = 1'b0;
      tick();
      hit(1, 0, 500);
      hit(0, 1, 507);
      wait_idle();
      tick();
      drain();
      chk("t6_count", log_q.size(), 1);
      expect_rec(0, 7, 0, 1);
      chk("t6_drop", drop_cnt, 0);

      // Randomized traffic against the model
      rdy_bias = 2;
      for (int i = 0; i < 4000; i++) begin
         if (i % 400 == 0) rdy_bias = $urandom_range(0, 4);
         start_hit  = ($urandom_range(0, 9) == 0);
         stop_hit   = ($urandom_range(0, 3) == 0);
         coarse_cnt = CW'($urandom);
         tof_ready  = ($urandom_range(0, 3) < rdy_bias);
         if ($urandom_range(0, 799) == 0) begin
            rst = 1'b1;
            model_reset();
            #1;
            chk("rnd_rst_busy", busy, 0);
            chk("rnd_rst_valid", tof_valid, 0);
         end
         tick();
         rst = 1'b0;
      end
      start_hit = 1'b0;
      stop_hit  = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
